// File: rtl/fc_argmax.sv
// Final-layer argmax: collects BCK_CELL neuron outputs from the FC write bus,
// then scans them one per cycle for the signed maximum (ties go to lowest index).
//
// state   | meaning
// IDLE    | waiting for enable; last result (if any) still presented
// COLLECT | capturing final-layer writes until all_end
// SCAN    | walking the buffer, one entry per cycle
// DONE    | result valid, held until enable drops
module fc_argmax #(
  parameter int BCK_CELL  = 10,
  parameter int ADDR_BASE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fc2_phase,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic        all_end,
  output logic [3:0]  class_idx,
  output logic [15:0] max_value,
  output logic        valid,
  output logic        busy,
  output logic        miss_err,
  output logic        addr_err
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_COLLECT = 2'd1;
  localparam logic [1:0]  S_SCAN    = 2'd2;
  localparam logic [1:0]  S_DONE    = 2'd3;
  localparam logic [3:0]  LAST_IDX  = 4'(BCK_CELL - 1);
  localparam logic [16:0] BASE      = 17'(ADDR_BASE);
  localparam logic [15:0] MIN_VAL   = 16'h8000;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [15:0]         r_buf [BCK_CELL];
  logic [BCK_CELL-1:0] r_mask;

  logic [3:0]  r_idx;
  logic        r_issuing;
  logic [15:0] r_cand;
  logic        r_cand_ok;
  logic        r_cand_vld;
  logic [3:0]  r_cand_idx;
  logic [15:0] r_run_max;
  logic [3:0]  r_run_idx;
  logic        r_found;

  logic [3:0]  r_class_idx;
  logic [15:0] r_max_value;
  logic        r_valid;
  logic        r_busy;
  logic        r_miss_err;
  logic        r_addr_err;

  logic [16:0] w_off;
  logic [3:0]  w_slot;
  logic        w_in_range;
  logic        w_wr;
  logic        w_take;
  logic        w_last;
  logic [15:0] w_nxt_max;
  logic [3:0]  w_nxt_idx;

  // 17-bit offset so an address below the base shows up as a borrow
  assign w_off      = {1'b0, addr} - BASE;
  assign w_slot     = w_off[3:0];
  assign w_in_range = !w_off[16] && (w_off[15:0] < 16'(BCK_CELL));
  assign w_wr       = (r_state == S_COLLECT) && we && fc2_phase;

  // The first written entry always wins; later ones must be strictly greater
  assign w_take    = r_cand_vld && r_cand_ok &&
                     (!r_found || ($signed(r_cand) > $signed(r_run_max)));
  assign w_nxt_max = w_take ? r_cand : r_run_max;
  assign w_nxt_idx = w_take ? r_cand_idx : r_run_idx;
  assign w_last    = r_cand_vld && (r_cand_idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (enable)  w_state_nxt = S_COLLECT;
      S_COLLECT: if (all_end) w_state_nxt = S_SCAN;
      S_SCAN:    if (w_last)  w_state_nxt = S_DONE;
      S_DONE:    if (!enable) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr && w_in_range) r_buf[w_slot] <= data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_idx       <= '0;
      r_issuing   <= 1'b0;
      r_cand      <= '0;
      r_cand_ok   <= 1'b0;
      r_cand_vld  <= 1'b0;
      r_cand_idx  <= '0;
      r_run_max   <= MIN_VAL;
      r_run_idx   <= '0;
      r_found     <= 1'b0;
      r_class_idx <= '0;
      r_max_value <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_miss_err  <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_COLLECT) || (w_state_nxt == S_SCAN);
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_mask     <= '0;
            r_addr_err <= 1'b0;
            r_miss_err <= 1'b0;
            r_valid    <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (w_wr) begin
            if (w_in_range) r_mask[w_slot] <= 1'b1;
            else            r_addr_err     <= 1'b1;
          end
          if (all_end) begin
            r_idx      <= '0;
            r_issuing  <= 1'b1;
            r_cand_vld <= 1'b0;
            r_run_max  <= MIN_VAL;
            r_run_idx  <= '0;
            r_found    <= 1'b0;
          end
        end
        S_SCAN: begin
          // Stage 1 reads an entry; stage 2 compares it a cycle later
          r_cand_vld <= r_issuing;
          if (r_issuing) begin
            r_cand     <= r_buf[r_idx];
            r_cand_ok  <= r_mask[r_idx];
            r_cand_idx <= r_idx;
            if (r_idx == LAST_IDX) r_issuing <= 1'b0;
            else                   r_idx     <= r_idx + 4'd1;
          end
          if (r_cand_vld) begin
            r_run_max <= w_nxt_max;
            r_run_idx <= w_nxt_idx;
            if (r_cand_ok) r_found    <= 1'b1;
            else           r_miss_err <= 1'b1;
          end
          if (w_last) begin
            r_class_idx <= w_nxt_idx;
            r_max_value <= w_nxt_max;
            r_valid     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign class_idx = r_class_idx;
  assign max_value = r_max_value;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign miss_err  = r_miss_err;
  assign addr_err  = r_addr_err;

endmodule
